// File: rtl/core_pkg.sv
// Shared core types: register address width and the per-stage pipeline entry.
package core_pkg;

  localparam int unsigned REG_AW = 5;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
  } stage_entry_t;

  // An entry produces src when it is live, writes, and src is not x0.
  function automatic logic entry_match(stage_entry_t e, logic [REG_AW-1:0] src);
    return e.valid & e.we & (e.rd == src) & (src != '0);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard detection, operand forwarding and occupancy tracking for DEPTH
// post-decode stages, with saturating stall/flush counters.
module pipe_hazard_unit
  import core_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  d_valid,
  input  logic [REG_AW-1:0]     d_rs1_addr,
  input  logic [REG_AW-1:0]     d_rs2_addr,
  input  logic                  d_rs1_use,
  input  logic                  d_rs2_use,
  input  logic [REG_AW-1:0]     d_rd_addr,
  input  logic                  d_rd_we,
  input  logic [XLEN-1:0]       rf_rs1_data,
  input  logic [XLEN-1:0]       rf_rs2_data,
  input  logic [DEPTH*XLEN-1:0] stg_result,
  input  logic [DEPTH-1:0]      stg_ready,
  input  logic                  mem_stall,
  input  logic                  redirect,
  output logic                  advance_D,
  output logic                  stall_D,
  output logic                  flush_D,
  output logic [XLEN-1:0]       rs1_fwd,
  output logic [XLEN-1:0]       rs2_fwd,
  output logic [DEPTH-1:0]      stg_valid,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  stage_entry_t     stg_q [DEPTH];
  logic [DEPTH-1:0] hit1;
  logic [DEPTH-1:0] hit2;
  logic             rdy1;
  logic             rdy2;
  logic             hazard;

  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    assign hit1[i]      = entry_match(stg_q[i], d_rs1_addr);
    assign hit2[i]      = entry_match(stg_q[i], d_rs2_addr);
    assign stg_valid[i] = stg_q[i].valid;
  end

  // Scan oldest to youngest so the lowest matching stage ends up winning.
  always_comb begin
    rs1_fwd = rf_rs1_data;
    rs2_fwd = rf_rs2_data;
    rdy1    = 1'b1;
    rdy2    = 1'b1;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (hit1[i]) begin
        rs1_fwd = stg_result[i*XLEN +: XLEN];
        rdy1    = stg_ready[i];
      end
      if (hit2[i]) begin
        rs2_fwd = stg_result[i*XLEN +: XLEN];
        rdy2    = stg_ready[i];
      end
    end
  end

  assign hazard    = (d_rs1_use & ~rdy1) | (d_rs2_use & ~rdy2);
  assign flush_D   = redirect & ~mem_stall;
  assign advance_D = d_valid & ~hazard & ~mem_stall & ~redirect;
  assign stall_D   = d_valid & ~advance_D & ~flush_D;

  // Stages shift together unless memory stalls; stage 0 gets decode or a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stg_q[i] <= '0;
      end
    end else if (!mem_stall) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stg_q[i] <= stg_q[i-1];
      end
      stg_q[0] <= advance_D ? {1'b1, d_rd_addr, d_rd_we} : '0;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_D),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_D),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed and randomized checks of pipe_hazard_unit against a pipeline-contents model.
module tb_pipe_hazard_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned CNT_W = 4;
  localparam int          CMAX  = 15;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  d_valid;
  logic [4:0]            d_rs1_addr, d_rs2_addr, d_rd_addr;
  logic                  d_rs1_use, d_rs2_use, d_rd_we;
  logic [XLEN-1:0]       rf_rs1_data, rf_rs2_data;
  logic [DEPTH*XLEN-1:0] stg_result;
  logic [DEPTH-1:0]      stg_ready;
  logic                  mem_stall, redirect;
  logic                  advance_D, stall_D, flush_D;
  logic [XLEN-1:0]       rs1_fwd, rs2_fwd;
  logic [DEPTH-1:0]      stg_valid;
  logic [CNT_W-1:0]      stall_cnt, flush_cnt;

  pipe_hazard_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid),
    .d_rs1_addr(d_rs1_addr), .d_rs2_addr(d_rs2_addr),
    .d_rs1_use(d_rs1_use), .d_rs2_use(d_rs2_use),
    .d_rd_addr(d_rd_addr), .d_rd_we(d_rd_we),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .stg_result(stg_result), .stg_ready(stg_ready),
    .mem_stall(mem_stall), .redirect(redirect),
    .advance_D(advance_D), .stall_D(stall_D), .flush_D(flush_D),
    .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd), .stg_valid(stg_valid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: what each tracked stage holds, plus expected counter values.
  bit         m_v  [DEPTH];
  logic [4:0] m_rd [DEPTH];
  bit         m_we [DEPTH];
  int         n_stall, n_flush;
  bit         e_adv, e_stall, e_flush;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int find_src(input logic [4:0] s);
    if (s == 5'd0) return -1;
    for (int i = 0; i < int'(DEPTH); i++)
      if (m_v[i] && m_we[i] && m_rd[i] == s) return i;
    return -1;
  endfunction

  function automatic logic [XLEN-1:0] res_of(input int i);
    return stg_result[i*XLEN +: XLEN];
  endfunction

  task automatic settle_check();
    int k1, k2;
    bit haz;
    logic [XLEN-1:0] f1, f2;
    logic [DEPTH-1:0] ev;
    #1;
    k1 = find_src(d_rs1_addr);
    k2 = find_src(d_rs2_addr);
    f1 = (k1 >= 0) ? res_of(k1) : rf_rs1_data;
    f2 = (k2 >= 0) ? res_of(k2) : rf_rs2_data;
    haz = (d_rs1_use && k1 >= 0 && !stg_ready[k1]) || (d_rs2_use && k2 >= 0 && !stg_ready[k2]);
    e_flush = redirect && !mem_stall;
    e_adv   = d_valid && !haz && !mem_stall && !redirect;
    e_stall = d_valid && !e_adv && !e_flush;
    for (int i = 0; i < int'(DEPTH); i++) ev[i] = m_v[i];
    check_val("rs1_fwd", 64'(rs1_fwd), 64'(f1));
    check_val("rs2_fwd", 64'(rs2_fwd), 64'(f2));
    check_val("advance_D", 64'(advance_D), 64'(e_adv));
    check_val("stall_D", 64'(stall_D), 64'(e_stall));
    check_val("flush_D", 64'(flush_D), 64'(e_flush));
    check_val("stg_valid", 64'(stg_valid), 64'(ev));
    check_val("stall_cnt", 64'(stall_cnt), 64'(n_stall));
    check_val("flush_cnt", 64'(flush_cnt), 64'(n_flush));
  endtask

  task automatic advance_clk();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin m_v[i] = 0; m_rd[i] = '0; m_we[i] = 0; end
      n_stall = 0;
      n_flush = 0;
    end else begin
      if (e_stall && n_stall < CMAX) n_stall++;
      if (e_flush && n_flush < CMAX) n_flush++;
      if (!mem_stall) begin
        for (int i = int'(DEPTH) - 1; i > 0; i--) begin
          m_v[i] = m_v[i-1]; m_rd[i] = m_rd[i-1]; m_we[i] = m_we[i-1];
        end
        m_v[0] = e_adv; m_rd[0] = e_adv ? d_rd_addr : 5'd0; m_we[0] = e_adv ? d_rd_we : 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic tick();
    settle_check();
    advance_clk();
  endtask

  task automatic set_d(input bit v, input logic [4:0] r1, input bit u1,
                       input logic [4:0] r2, input bit u2, input logic [4:0] rd, input bit we);
    d_valid = v; d_rs1_addr = r1; d_rs1_use = u1;
    d_rs2_addr = r2; d_rs2_use = u2; d_rd_addr = rd; d_rd_we = we;
  endtask

  task automatic set_idle();
    set_d(0, 0, 0, 0, 0, 0, 0);
    rf_rs1_data = '0; rf_rs2_data = '0; stg_result = '0;
    stg_ready = '1; mem_stall = 0; redirect = 0;
  endtask

  task automatic reset_dut();
    set_idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic issue(input logic [4:0] rd);
    set_d(1, 0, 0, 0, 0, rd, 1);
    tick();
  endtask

  initial begin
    set_idle();
    reset = 1;
    for (int i = 0; i < int'(DEPTH); i++) begin m_v[i] = 0; m_rd[i] = '0; m_we[i] = 0; end
    n_stall = 0; n_flush = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_dut();

    // Back-to-back ALU dependency
    issue(5'd5);
    set_d(1, 5, 1, 0, 0, 1, 0);
    stg_result[0*XLEN +: XLEN] = 32'h1234;
    settle_check();
    check_val("alu_fwd", 64'(rs1_fwd), 64'h1234);
    check_val("alu_adv", 64'(advance_D), 64'd1);
    advance_clk();

    // Load-use stall then forward
    reset_dut();
    issue(5'd7);
    set_d(1, 0, 0, 7, 1, 2, 1);
    stg_ready = 3'b110;
    settle_check();
    check_val("lu_stall", 64'(stall_D), 64'd1);
    advance_clk();
    stg_ready = 3'b111;
    stg_result[1*XLEN +: XLEN] = 32'hCAFE;
    settle_check();
    check_val("lu_valid", 64'(stg_valid), 64'b010);
    check_val("lu_fwd", 64'(rs2_fwd), 64'hCAFE);
    check_val("lu_adv", 64'(advance_D), 64'd1);
    check_val("lu_cnt", 64'(stall_cnt), 64'd1);
    advance_clk();

    // Youngest producer wins; x0 never forwards
    reset_dut();
    issue(5'd3); issue(5'd9); issue(5'd3);
    set_d(1, 3, 1, 0, 0, 0, 0);
    stg_result = {32'hBBBB, 32'h1111, 32'hAAAA};
    settle_check();
    check_val("prio_fwd", 64'(rs1_fwd), 64'hAAAA);
    advance_clk();
    reset_dut();
    issue(5'd0); issue(5'd0); issue(5'd0);
    set_d(1, 0, 1, 0, 1, 4, 1);
    stg_result = {32'h3, 32'h2, 32'h1};
    stg_ready = 3'b000;
    settle_check();
    check_val("x0_fwd", 64'(rs1_fwd), 64'd0);
    check_val("x0_stall", 64'(stall_D), 64'd0);
    advance_clk();

    // mem_stall with pending redirect
    reset_dut();
    issue(5'd1);
    set_idle(); tick();
    issue(5'd2);
    set_d(1, 0, 0, 0, 0, 6, 1);
    mem_stall = 1; redirect = 1;
    for (int c = 0; c < 4; c++) begin
      settle_check();
      check_val("ms_flush", 64'(flush_D), 64'd0);
      advance_clk();
    end
    mem_stall = 0;
    settle_check();
    check_val("ms_valid", 64'(stg_valid), 64'b101);
    check_val("ms_scnt", 64'(stall_cnt), 64'd4);
    check_val("ms_flush1", 64'(flush_D), 64'd1);
    advance_clk();
    set_idle();
    settle_check();
    check_val("ms_fcnt", 64'(flush_cnt), 64'd1);
    advance_clk();

    // Stall counter saturation
    reset_dut();
    set_d(1, 0, 0, 0, 0, 0, 0);
    mem_stall = 1;
    repeat (20) tick();
    settle_check();
    check_val("sat_cnt", 64'(stall_cnt), 64'd15);
    advance_clk();

    // Reset during a stall
    reset_dut();
    issue(5'd1); issue(5'd2); issue(5'd3);
    mem_stall = 1;
    settle_check();
    check_val("rst_full", 64'(stg_valid), 64'b111);
    advance_clk();
    reset = 1;
    tick();
    reset = 0;
    set_idle();
    settle_check();
    check_val("rst_valid", 64'(stg_valid), 64'd0);
    check_val("rst_scnt", 64'(stall_cnt), 64'd0);
    check_val("rst_ctl", 64'({advance_D, stall_D, flush_D}), 64'd0);
    advance_clk();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(99) < 2);
      d_valid     = ($urandom_range(3) != 0);
      d_rs1_addr  = 5'($urandom_range(7));
      d_rs2_addr  = 5'($urandom_range(7));
      d_rs1_use   = 1'($urandom_range(1));
      d_rs2_use   = 1'($urandom_range(1));
      d_rd_addr   = 5'($urandom_range(7));
      d_rd_we     = ($urandom_range(3) != 0);
      rf_rs1_data = $urandom;
      rf_rs2_data = $urandom;
      for (int i = 0; i < int'(DEPTH); i++) begin
        stg_result[i*XLEN +: XLEN] = $urandom;
        stg_ready[i] = ($urandom_range(3) != 0);
      end
      mem_stall = ($urandom_range(99) < 20);
      redirect  = ($urandom_range(99) < 15);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
